vga_timing_pipe: RTL and testbench
==================================

Name: vga_timing_pipe

Overview:
- Parametrised VGA timing generator and pixel output stage. Successor to the fixed-640x480 controller used in the VGA image top level.
- Generates h/v counters, requests pixels from an upstream generator or ROM by address, and absorbs a configurable upstream read latency.
- Sync and blank are delayed to line up with the returned pixel data.
- Sits between the pixel source (data_gen or image ROM) and the DAC pins (ADV7123-style: blank_n, sync_n, vga_clk).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
DATA_LAT, 1, cycles from h_addr/v_addr to data_dis valid (legal range 0..4)
COLOR_W, 8, bits per colour channel
ADDR_W, 11, width of h_addr and v_addr

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
en  in  1  timing run enable
data_dis  in  3*COLOR_W  pixel {R,G,B}, valid DATA_LAT cycles after its address
h_addr  out  ADDR_W  requested column; equals h_cnt when req_valid=1, else 0
v_addr  out  ADDR_W  requested row; equals v_cnt when req_valid=1, else 0
req_valid  out  1  h_addr/v_addr are inside the active area
frame_start  out  1  one-cycle pulse when h_cnt=0 and v_cnt=0 (counter side)
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
hsync  out  1  horizontal sync, level per H_POL
vsync  out  1  vertical sync, level per V_POL
sync  out  1  composite sync_n, tied 1 (sync-on-green disabled)
vga_blk  out  1  blank_n: 1 during active pixels
vga_r/vga_g/vga_b  out  COLOR_W each  pixel channels, 0 while blanked
vga_clk  out  1  inverted clk to the DAC

Behaviour:
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise.
- h_cnt counts 0..H_TOT-1 and wraps to 0. v_cnt increments only on the h_cnt wrap, counts 0..V_TOT-1 and wraps.
- Line order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical order is identical.
- req_valid = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE) && en. It is combinational from the counter registers.
- Raw hsync/vsync/active flags enter a shift pipeline of DATA_LAT+1 registered stages.
- The output register captures data_dis when the delayed active flag is 1, otherwise 0.
- Alignment: the pixel for address (x,y) issued at cycle t appears on vga_r/g/b at t+DATA_LAT+1, in the same cycle that the delayed vga_blk=1 and delayed hsync/vsync correspond to (x,y).
- frame_cnt increments on the cycle h_cnt and v_cnt both wrap (last pixel of the frame).
- Reset (async assert, sync release): h_cnt=v_cnt=0, all pipeline stages cleared, frame_cnt=0. Outputs go to:
  - hsync=~H_POL, vsync=~V_POL
  - vga_blk=0, rgb=0
  - req_valid=0, frame_start=0
- en=0: counters are cleared to 0 on the next edge and held. The pipeline keeps shifting with inactive inputs, so outputs reach the idle state after DATA_LAT+1 cycles.
- en 0->1: counting starts at (0,0) and frame_start pulses on the first enabled cycle. frame_cnt is not cleared by en.
- Reset asserted mid-frame: immediate idle outputs, no partial pipeline flush is visible.
- Width rule: ADDR_W must hold max(H_TOT, V_TOT)-1; an out-of-range configuration is a static elaboration error.

Optional Feature:
- Macro VGA_TESTPAT_EN.
- When defined, adds input test_en (1 bit). While test_en=1, data_dis is ignored and the pipeline input is an 8-bar colour pattern: bar index = (h_cnt*8)/H_ACTIVE.
  - Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is all-ones or 0.
  - The pattern is delayed through the same DATA_LAT stages so alignment is unchanged.
- When the macro is undefined: no test_en port and no pattern logic.

Test Plan:
- Small mode H_ACTIVE=8,H_FP=2,H_SYNC=3,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=2,V_BP=1, DATA_LAT=1: after reset release with en=1 -> hsync low for exactly 3 of every 15 clocks and vsync low for exactly 2 lines (30 clocks) of 8.
- Same mode with a model returning data_dis={x,y,x^y} one cycle after the address -> vga_r=x, vga_g=y appear 2 cycles after the request, with vga_blk=1 on exactly 32 cycles per frame.
- DATA_LAT=3 -> first active pixel and vga_blk rise 4 cycles after req_valid rises; the hsync edge shifts by the same 4.
- rst pulsed mid-line (h_cnt=5, v_cnt=2) -> the same cycle shows hsync=vsync=1, vga_blk=0, rgb=0; after release the next frame_start occurs immediately.
- en dropped for 20 cycles, then raised -> outputs idle DATA_LAT+1 cycles after the drop; frame_start pulses on the first enabled cycle and frame_cnt is unchanged.
- Run 3 full frames -> frame_cnt=3. Force frame_cnt to 0xFFFF and run one frame -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with a latency-matched pixel output stage.
// Optional colour-bar source is compiled in with `define VGA_TESTPAT_EN.
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int DATA_LAT = 1,
  parameter int COLOR_W  = 8,
  parameter int ADDR_W   = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
`ifdef VGA_TESTPAT_EN
  input  logic                   test_en,
`endif
  input  logic [3*COLOR_W-1:0]   data_dis,
  output logic [ADDR_W-1:0]      h_addr,
  output logic [ADDR_W-1:0]      v_addr,
  output logic                   req_valid,
  output logic                   frame_start,
  output logic [15:0]            frame_cnt,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   sync,
  output logic                   vga_blk,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vga_clk
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(H_TOT - 1);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(V_TOT - 1);
  localparam logic [ADDR_W-1:0] H_ACT  = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_ACT  = ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HS_BEG = ADDR_W'(H_ACTIVE + H_FP);
  localparam logic [ADDR_W-1:0] HS_END = ADDR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ADDR_W-1:0] VS_BEG = ADDR_W'(V_ACTIVE + V_FP);
  localparam logic [ADDR_W-1:0] VS_END = ADDR_W'(V_ACTIVE + V_FP + V_SYNC);

  if ((H_TOT - 1) >= (1 << ADDR_W) || (V_TOT - 1) >= (1 << ADDR_W)) begin : g_bad_width
    $error("vga_timing_pipe: ADDR_W too narrow for the configured totals");
  end
  if (DATA_LAT < 0 || DATA_LAT > 4) begin : g_bad_lat
    $error("vga_timing_pipe: DATA_LAT must be within 0..4");
  end

  logic [ADDR_W-1:0] h_cnt;
  logic [ADDR_W-1:0] v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        v_cnt <= v_cnt + ADDR_W'(1);
      end
    end else begin
      h_cnt <= h_cnt + ADDR_W'(1);
    end
  end

  // Reset gates the combinational request side so it is idle while rst is held.
  logic live;
  logic raw_hs;
  logic raw_vs;
  logic raw_act;

  assign live        = en & ~rst;
  assign req_valid   = live & (h_cnt < H_ACT) & (v_cnt < V_ACT);
  assign raw_act     = req_valid;
  assign h_addr      = req_valid ? h_cnt : '0;
  assign v_addr      = req_valid ? v_cnt : '0;
  assign frame_start = live & (h_cnt == '0) & (v_cnt == '0);
  assign raw_hs      = live & (h_cnt >= HS_BEG) & (h_cnt < HS_END);
  assign raw_vs      = live & (v_cnt >= VS_BEG) & (v_cnt < VS_END);

  // stg[k] holds {hs, vs, act} delayed k+1 cycles; stg[DATA_LAT] drives the pins.
  logic [2:0] stg [DATA_LAT+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i <= DATA_LAT; i++) stg[i] <= '0;
    end else begin
      stg[0] <= {raw_hs, raw_vs, raw_act};
      for (int unsigned i = 1; i <= DATA_LAT; i++) stg[i] <= stg[i-1];
    end
  end

  logic tap_act;
  if (DATA_LAT == 0) begin : g_tap0
    assign tap_act = raw_act;
  end else begin : g_tapn
    assign tap_act = stg[DATA_LAT-1][0];
  end

  logic [3*COLOR_W-1:0] pix;

`ifdef VGA_TESTPAT_EN
  localparam int PD = (DATA_LAT > 0) ? DATA_LAT : 1;

  logic [ADDR_W+2:0]  bar_full;
  logic [2:0]         bar;
  logic [3*COLOR_W:0] pat_src;
  logic [3*COLOR_W:0] pat_tap;
  logic [3*COLOR_W:0] pat_q [PD];

  assign bar_full = {h_cnt, 3'b000} / (ADDR_W+3)'(H_ACTIVE);
  assign bar      = bar_full[2:0];
  // Bars white..black: R off for bars 2,3,6,7, G off for 4..7, B off for odd bars.
  assign pat_src  = {test_en, {COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PD; i++) pat_q[i] <= '0;
    end else begin
      pat_q[0] <= pat_src;
      for (int unsigned i = 1; i < PD; i++) pat_q[i] <= pat_q[i-1];
    end
  end

  if (DATA_LAT == 0) begin : g_pat0
    assign pat_tap = pat_src;
  end else begin : g_patn
    assign pat_tap = pat_q[DATA_LAT-1];
  end

  assign pix = pat_tap[3*COLOR_W] ? pat_tap[3*COLOR_W-1:0] : data_dis;
`else
  assign pix = data_dis;
`endif

  logic [3*COLOR_W-1:0] rgb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_q <= '0;
    else     rgb_q <= tap_act ? pix : '0;
  end

  assign vga_r   = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g   = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b   = rgb_q[COLOR_W-1:0];
  assign vga_blk = stg[DATA_LAT][0];
  assign hsync   = H_POL ? stg[DATA_LAT][2] : ~stg[DATA_LAT][2];
  assign vsync   = V_POL ? stg[DATA_LAT][1] : ~stg[DATA_LAT][1];
  assign sync    = 1'b1;
  assign vga_clk = ~clk;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench for vga_timing_pipe in a 15x8 small mode, DATA_LAT=1 and DATA_LAT=3.
module tb_vga_timing_pipe;
  localparam int CW = 8;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic [3*CW-1:0] dd_a, dd_b, db1, db2;
  logic [AW-1:0]   h_addr_a, v_addr_a, h_addr_b, v_addr_b;
  logic            req_valid_a, frame_start_a, req_valid_b, frame_start_b;
  logic [15:0]     frame_cnt_a, frame_cnt_b;
  logic            hsync_a, vsync_a, sync_a, vga_blk_a, vga_clk_a;
  logic            hsync_b, vsync_b, sync_b, vga_blk_b, vga_clk_b;
  logic [CW-1:0]   vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .DATA_LAT(1), .COLOR_W(CW), .ADDR_W(AW)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .data_dis(dd_a),
    .h_addr(h_addr_a), .v_addr(v_addr_a), .req_valid(req_valid_a),
    .frame_start(frame_start_a), .frame_cnt(frame_cnt_a),
    .hsync(hsync_a), .vsync(vsync_a), .sync(sync_a), .vga_blk(vga_blk_a),
    .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a), .vga_clk(vga_clk_a)
  );

  vga_timing_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .DATA_LAT(3), .COLOR_W(CW), .ADDR_W(AW)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .data_dis(dd_b),
    .h_addr(h_addr_b), .v_addr(v_addr_b), .req_valid(req_valid_b),
    .frame_start(frame_start_b), .frame_cnt(frame_cnt_b),
    .hsync(hsync_b), .vsync(vsync_b), .sync(sync_b), .vga_blk(vga_blk_b),
    .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b), .vga_clk(vga_clk_b)
  );

  // Upstream pixel source: returns {x, y, x^y} DATA_LAT cycles after the address.
  always @(posedge clk) begin
    dd_a <= {h_addr_a[7:0], v_addr_a[7:0], h_addr_a[7:0] ^ v_addr_a[7:0]};
    db1  <= {h_addr_b[7:0], v_addr_b[7:0], h_addr_b[7:0] ^ v_addr_b[7:0]};
    db2  <= db1;
    dd_b <= db2;
  end

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [7:0] x;
    logic [7:0] y;
  } ent_t;

  ent_t        hist [4];
  int          mh, mv;
  logic [15:0] mf;
  int          checks = 0;
  int          failures = 0;
  bit          counting = 1'b0;
  int          hs_low, vs_low, blk_hi;
  logic [15:0] fc_saved;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    mh = 0;
    mv = 0;
    mf = 16'h0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
  endtask

  function automatic logic [26:0] out_vec(input ent_t e);
    return {~e.hs, ~e.vs, e.act, e.act ? {e.x, e.y, e.x ^ e.y} : 24'h0};
  endfunction

  function automatic logic [39:0] ctr_vec();
    logic live, req;
    live = en && !rst;
    req  = live && mh < 8 && mv < 4;
    return {req, live && mh == 0 && mv == 0,
            req ? AW'(mh) : AW'(0), req ? AW'(mv) : AW'(0), mf};
  endfunction

  task automatic update_model();
    ent_t e;
    if (rst) begin
      clear_model();
    end else begin
      e.act = en && mh < 8 && mv < 4;
      e.hs  = en && mh >= 10 && mh <= 12;
      e.vs  = en && mv >= 5 && mv <= 6;
      e.x   = 8'(mh);
      e.y   = 8'(mv);
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = e;
      if (!en) begin
        mh = 0;
        mv = 0;
      end else if (mh == 14) begin
        mh = 0;
        if (mv == 7) begin
          mv = 0;
          mf = mf + 16'd1;
        end else mv++;
      end else mh++;
    end
  endtask

  task automatic compare();
    if (rst) clear_model();
    check("out_a", {hsync_a, vsync_a, vga_blk_a, vga_r_a, vga_g_a, vga_b_a}, out_vec(hist[1]));
    check("out_b", {hsync_b, vsync_b, vga_blk_b, vga_r_b, vga_g_b, vga_b_b}, out_vec(hist[3]));
    check("ctr_a", {req_valid_a, frame_start_a, h_addr_a, v_addr_a, frame_cnt_a}, ctr_vec());
    check("ctr_b", {req_valid_b, frame_start_b, h_addr_b, v_addr_b, frame_cnt_b}, ctr_vec());
    check("pins", {sync_a, vga_clk_a, sync_b, vga_clk_b}, 4'b1111);
    if (counting) begin
      hs_low += int'(!hsync_a);
      vs_low += int'(!vsync_a);
      blk_hi += int'(vga_blk_a);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      update_model();
      @(negedge clk);
      compare();
    end
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    en  = 1'b1;
    step(3);

    // Release: counters at (0,0), frame_start on the very first cycle.
    rst = 1'b0;
    #1 compare();
    step(119);
    step(1);

    hs_low = 0; vs_low = 0; blk_hi = 0;
    counting = 1'b1;
    step(120);
    counting = 1'b0;
    check("hs_low_per_frame", 64'(hs_low), 64'd24);
    check("vs_low_per_frame", 64'(vs_low), 64'd30);
    check("blk_hi_per_frame", 64'(blk_hi), 64'd32);

    step(120);
    check("frame_cnt_3", 64'(frame_cnt_a), 64'd3);

    // Reset mid-line at (5,2): idle outputs in the same cycle.
    for (int i = 0; i < 200 && !(mh == 5 && mv == 2); i++) step(1);
    check("reached_5_2", {32'(mh), 32'(mv)}, {32'd5, 32'd2});
    rst = 1'b1;
    #1 compare();
    check("rst_idle_a", {hsync_a, vsync_a, vga_blk_a, vga_r_a, vga_g_a, vga_b_a},
          {1'b1, 1'b1, 1'b0, 24'h0});
    step(2);
    rst = 1'b0;
    #1 compare();
    check("fs_after_rst", 64'(frame_start_a), 64'd1);

    // Enable drop for 20 cycles.
    step(30);
    fc_saved = mf;
    en = 1'b0;
    step(20);
    en = 1'b1;
    #1 compare();
    check("fs_after_en", 64'(frame_start_a), 64'd1);
    check("fc_en_hold", 64'(frame_cnt_a), 64'(fc_saved));

    // Counter wrap from 0xFFFF at a frame boundary.
    force dut_a.frame_cnt = 16'hFFFF;
    force dut_b.frame_cnt = 16'hFFFF;
    #1;
    release dut_a.frame_cnt;
    release dut_b.frame_cnt;
    mf = 16'hFFFF;
    check("fc_forced", 64'(frame_cnt_a), 64'hFFFF);
    step(120);
    check("fc_wrap_a", 64'(frame_cnt_a), 64'h0);
    check("fc_wrap_b", 64'(frame_cnt_b), 64'h0);

    step(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
